mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle MIPS control FSM. It sequences the shared datapath: one memory port, one ALU, the IR, the PC and the register file. The instruction set is addu, subu, ori, lw, sw, beq, lui, j, jal and jr. It sits beside the datapath, decodes op/func from the IR, and drives every mux select and write strobe each cycle. It stalls on a memory-ready handshake and flags illegal opcodes and memory timeouts.

Parameters:
WAIT_LIMIT, 15, max consecutive mem_ready=0 cycles tolerated in a memory state before abort (1..255).
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
op  in  6  IR[31:26]
func  in  6  IR[5:0]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if zero=1 (beq)
IorD  out  1  memory address: 0=PC, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  IR load
RegDst  out  2  00=rt, 01=rd, 10=$31
MemtoReg  out  2  00=ALUOut, 01=MDR, 10=PC
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=regA
ALUSrcB  out  2  00=regB, 01=4, 10=ext imm, 11=ext imm<<2
ALUOp  out  2  00=add, 01=sub, 10=or, 11=pass B
ExtOp  out  2  00=zero, 01=sign, 10=imm<<16
PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target, 11=rs
jr  out  1  jr in progress
instr_done  out  1  one-cycle pulse in the last cycle of each instruction
illegal  out  1  one-cycle pulse on an undecodable instruction
mem_err  out  1  one-cycle pulse on memory timeout
state_o  out  4  current state encoding, for debug
cycle_cnt  out  CNT_W  cycles since reset
instr_cnt  out  CNT_W  retired instructions

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst_n asynchronous, active-low.
  - Reset puts state in FETCH and clears the wait counter and perf counters.
  - While rst_n=0: all strobes (PCWrite, PCWriteCond, MemRead, MemWrite, IRWrite, RegWrite) are 0, all selects are 0, pulses are 0.
  - Reset mid-instruction aborts the instruction immediately; no partial write follows.
- Outputs are Moore-decoded from state. In memory states, the write strobes are additionally ANDed with mem_ready.
- Opcodes: R=000000 (addu func 100001, subu 100011, jr 001000), ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, j 000010, jal 000011.
- States:
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. When mem_ready=1: IRWrite=1, PCWrite=1, go to DECODE. Otherwise stay.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ExtOp=01, ALUOp=00 (branch target into ALUOut). Dispatch on op/func:
    - lw/sw → MEM_ADR
    - addu/subu → EXEC_R
    - ori/lui → EXEC_I
    - beq → BRANCH
    - j → JUMP
    - jal → JAL
    - jr → JR
    - anything else → FETCH with illegal=1
  - MEM_ADR: ALUSrcA=1, ALUSrcB=10, ExtOp=01, ALUOp=00. Go to MEM_RD (lw) or MEM_WR (sw).
  - MEM_RD: MemRead=1, IorD=1. When mem_ready=1, go to MEM_WB.
  - MEM_WB: RegWrite=1, RegDst=00, MemtoReg=01. Go to FETCH.
  - MEM_WR: MemWrite=mem_ready, IorD=1. When mem_ready=1, go to FETCH.
  - EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=00 (addu) or 01 (subu).
  - EXEC_I: ALUSrcA=1, ALUSrcB=10. For ori: ExtOp=00, ALUOp=10. For lui: ExtOp=10, ALUOp=11.
  - ALU_WB: RegWrite=1, MemtoReg=00. RegDst=01 after EXEC_R, 00 after EXEC_I. Go to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Go to FETCH.
  - JUMP: PCWrite=1, PCSource=10. Go to FETCH.
  - JAL: PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10 (PC is already +4). Go to FETCH.
  - JR: PCWrite=1, PCSource=11, jr=1. Go to FETCH.
- Latency with zero wait states:
  - beq, j, jal, jr: 3 cycles
  - addu, subu, ori, lui, sw: 4 cycles
  - lw: 5 cycles
  - Each mem_ready=0 cycle adds 1.
- instr_done is high in the final state of each instruction: MEM_WB, MEM_WR with mem_ready=1, ALU_WB, BRANCH, JUMP, JAL, JR.
- Wait counter:
  - Counts consecutive mem_ready=0 cycles in FETCH, MEM_RD and MEM_WR; clears on state change.
  - When the count reaches WAIT_LIMIT with mem_ready still 0: mem_err=1 for one cycle and the state goes to FETCH (a FETCH restarts), with no IRWrite, RegWrite or MemWrite.
  - mem_ready=1 in the limit cycle completes normally and does not raise mem_err.
- op/func are trusted only from DECODE onward; the IR changes only in FETCH.

Optional Feature:
- Macro MC_CTRL_PERF_EN.
- Defined:
  - cycle_cnt increments every cycle out of reset.
  - instr_cnt increments on each instr_done.
  - Both wrap from all-ones to 0.
  - Illegal and aborted instructions do not count toward instr_cnt.
- Undefined: cycle_cnt and instr_cnt are tied to 0 and no counter flops are built.

Test Plan:
- Reset released, mem_ready=1, IR=addu (op 000000, func 100001) → DECODE, EXEC_R, ALU_WB on cycles 2-4; RegWrite=1, RegDst=01 on cycle 4; instr_done=1 once.
- lw (op 100011) with mem_ready low 2 cycles in MEM_RD → 7 cycles total; IorD=1 throughout MEM_RD; RegWrite=1, MemtoReg=01 in MEM_WB.
- beq (op 000100), zero=1 then zero=0 → 3 cycles each; PCWriteCond=1, PCSource=01 in BRANCH; PCWrite=0.
- jal (op 000011) → JAL state has PCWrite=1, PCSource=10, RegDst=10, MemtoReg=10, RegWrite=1. jr (func 001000) → jr=1, PCSource=11.
- op=111111 → illegal=1 in DECODE, next state FETCH, no RegWrite. sw with mem_ready held 0 for 15 cycles → mem_err=1, back to FETCH, MemWrite never 1.
- rst_n pulsed low mid-MEM_WR → strobes drop to 0 immediately and state_o shows FETCH. With MC_CTRL_PERF_EN: after 3 addu, instr_cnt=3 and cycle_cnt=12.

Source files
------------

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences the shared memory/ALU datapath and
// supervises the memory handshake. Define MC_CTRL_PERF_EN to build the perf counters.
module mc_ctrl #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ExtOp,
  output logic [1:0]       PCSource,
  output logic             jr,
  output logic             instr_done,
  output logic             illegal,
  output logic             mem_err,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE = 4'd1,  MEM_ADR = 4'd2,  MEM_RD = 4'd3,
    MEM_WB  = 4'd4,  MEM_WR = 4'd5,  EXEC_R  = 4'd6,  EXEC_I = 4'd7,
    ALU_WB  = 4'd8,  BRANCH = 4'd9,  JUMP    = 4'd10, JAL    = 4'd11,
    JR      = 4'd12
  } state_t;

  state_t     state;
  logic [7:0] waitCnt;

  // The branch decision itself is made in the datapath (PCWriteCond & zero).
  logic unusedZero;
  assign unusedZero = zero;

  logic isR, isAddu, isSubu, isJr, isOri, isLw, isSw, isBeq, isLui, isJ, isJal, isLegal;
  assign isR     = (op == 6'b000000);
  assign isAddu  = isR && (func == 6'b100001);
  assign isSubu  = isR && (func == 6'b100011);
  assign isJr    = isR && (func == 6'b001000);
  assign isOri   = (op == 6'b001101);
  assign isLw    = (op == 6'b100011);
  assign isSw    = (op == 6'b101011);
  assign isBeq   = (op == 6'b000100);
  assign isLui   = (op == 6'b001111);
  assign isJ     = (op == 6'b000010);
  assign isJal   = (op == 6'b000011);
  assign isLegal = isAddu | isSubu | isJr | isOri | isLw | isSw | isBeq | isLui | isJ | isJal;

  logic memState, timeout;
  assign memState = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  // waitCnt holds the stalls already seen, so this cycle is the WAIT_LIMIT-th one.
  assign timeout  = memState && !mem_ready && (waitCnt == 8'(WAIT_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      waitCnt <= 8'd0;
    end else begin
      waitCnt <= (memState && !mem_ready && !timeout) ? waitCnt + 8'd1 : 8'd0;
      case (state)
        FETCH:   if (mem_ready) state <= DECODE;
        DECODE: begin
          if (isLw || isSw)          state <= MEM_ADR;
          else if (isAddu || isSubu) state <= EXEC_R;
          else if (isOri || isLui)   state <= EXEC_I;
          else if (isBeq)            state <= BRANCH;
          else if (isJ)              state <= JUMP;
          else if (isJal)            state <= JAL;
          else if (isJr)             state <= JR;
          else                       state <= FETCH;
        end
        MEM_ADR: state <= isLw ? MEM_RD : MEM_WR;
        MEM_RD:  if (mem_ready) state <= MEM_WB; else if (timeout) state <= FETCH;
        MEM_WR:  if (mem_ready || timeout) state <= FETCH;
        EXEC_R,
        EXEC_I:  state <= ALU_WB;
        default: state <= FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite = 1'b0; PCWriteCond = 1'b0; IorD = 1'b0; MemRead = 1'b0;
    MemWrite = 1'b0; IRWrite = 1'b0; RegDst = 2'b00; MemtoReg = 2'b00;
    RegWrite = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 2'b00; ALUOp = 2'b00;
    ExtOp = 2'b00; PCSource = 2'b00; jr = 1'b0; instr_done = 1'b0;
    illegal = 1'b0; mem_err = 1'b0;
    // Everything is held quiet while reset is asserted, even though state reads FETCH.
    if (rst_n) begin
      case (state)
        FETCH: begin
          MemRead = 1'b1; ALUSrcB = 2'b01;
          IRWrite = mem_ready; PCWrite = mem_ready; mem_err = timeout;
        end
        DECODE: begin
          ALUSrcB = 2'b11; ExtOp = 2'b01; illegal = !isLegal;
        end
        MEM_ADR: begin
          ALUSrcA = 1'b1; ALUSrcB = 2'b10; ExtOp = 2'b01;
        end
        MEM_RD: begin
          MemRead = 1'b1; IorD = 1'b1; mem_err = timeout;
        end
        MEM_WB: begin
          RegWrite = 1'b1; MemtoReg = 2'b01; instr_done = 1'b1;
        end
        MEM_WR: begin
          MemWrite = mem_ready; IorD = 1'b1; instr_done = mem_ready; mem_err = timeout;
        end
        EXEC_R: begin
          ALUSrcA = 1'b1; ALUOp = isSubu ? 2'b01 : 2'b00;
        end
        EXEC_I: begin
          ALUSrcA = 1'b1; ALUSrcB = 2'b10;
          ExtOp = isLui ? 2'b10 : 2'b00; ALUOp = isLui ? 2'b11 : 2'b10;
        end
        ALU_WB: begin
          // IR is stable until the next FETCH, so op still tells R-type from I-type.
          RegWrite = 1'b1; RegDst = isR ? 2'b01 : 2'b00; instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA = 1'b1; ALUOp = 2'b01; PCWriteCond = 1'b1; PCSource = 2'b01;
          instr_done = 1'b1;
        end
        JUMP: begin
          PCWrite = 1'b1; PCSource = 2'b10; instr_done = 1'b1;
        end
        JAL: begin
          PCWrite = 1'b1; PCSource = 2'b10; RegWrite = 1'b1;
          RegDst = 2'b10; MemtoReg = 2'b10; instr_done = 1'b1;
        end
        JR: begin
          PCWrite = 1'b1; PCSource = 2'b11; jr = 1'b1; instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] cycleCnt, instrCnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycleCnt <= '0;
      instrCnt <= '0;
    end else begin
      cycleCnt <= cycleCnt + 1'b1;
      if (instr_done) instrCnt <= instrCnt + 1'b1;
    end
  end
  assign cycle_cnt = cycleCnt;
  assign instr_cnt = instrCnt;
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: walks each instruction class through its states,
// stalls and times out the memory handshake, and resets mid-store.
module tb_mc_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op, func;
  logic        zero, mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0]  RegDst, MemtoReg, ALUSrcB, ALUOp, ExtOp, PCSource;
  logic        jr, instr_done, illegal, mem_err;
  logic [3:0]  state_o;
  logic [31:0] cycle_cnt, instr_cnt;

  mc_ctrl #(.WAIT_LIMIT(15), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ExtOp(ExtOp), .PCSource(PCSource), .jr(jr), .instr_done(instr_done),
    .illegal(illegal), .mem_err(mem_err), .state_o(state_o),
    .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADR = 4'd2, S_MEM_RD = 4'd3,
                         S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7,
                         S_ALU_WB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_JAL = 4'd11,
                         S_JR = 4'd12;

  int nCmp = 0;
  int nErr = 0;
  int cyc  = 0;
  int t0   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic startInstr(input logic [5:0] o, input logic [5:0] f);
    op = o; func = f; mem_ready = 1'b1; t0 = cyc;
    check("fetch.state", state_o, S_FETCH);
    check("fetch.irwrite", IRWrite, 1'b1);
  endtask

  task automatic endInstr(input string tag, input int expLen);
    check({tag, ".len"}, cyc - t0, expLen);
    check({tag, ".back"}, state_o, S_FETCH);
    $display("txn %s cycles=%0d", tag, cyc - t0);
  endtask

  int doneCnt;
  logic wrSeen, errSeen;

  initial begin
    rst_n = 1'b0; op = 6'b000000; func = 6'b100001; zero = 1'b0; mem_ready = 1'b1;
    #12;
    check("rst.state", state_o, S_FETCH);
    check("rst.memread", MemRead, 1'b0);
    check("rst.alusrcb", ALUSrcB, 2'b00);
    check("rst.pcwrite", PCWrite, 1'b0);
    @(negedge clk); rst_n = 1'b1; #1;

    // addu x3 straight out of reset
    startInstr(6'b000000, 6'b100001);
    check("addu.fetch.memread", MemRead, 1'b1);
    check("addu.fetch.pcwrite", PCWrite, 1'b1);
    check("addu.fetch.alusrcb", ALUSrcB, 2'b01);
    tick();
    check("addu.dec.state", state_o, S_DECODE);
    check("addu.dec.alusrcb", ALUSrcB, 2'b11);
    check("addu.dec.extop", ExtOp, 2'b01);
    tick();
    check("addu.exe.state", state_o, S_EXEC_R);
    check("addu.exe.alusrca", ALUSrcA, 1'b1);
    check("addu.exe.aluop", ALUOp, 2'b00);
    tick();
    check("addu.wb.state", state_o, S_ALU_WB);
    check("addu.wb.regwrite", RegWrite, 1'b1);
    check("addu.wb.regdst", RegDst, 2'b01);
    check("addu.wb.done", instr_done, 1'b1);
    tick();
    endInstr("addu1", 4);
    for (int k = 0; k < 2; k++) begin
      startInstr(6'b000000, 6'b100001);
      doneCnt = 0;
      for (int c = 0; c < 4; c++) begin
        doneCnt += int'(instr_done);
        tick();
      end
      check("addu.donecnt", doneCnt, 1);
      endInstr("addu", 4);
    end
`ifdef MC_CTRL_PERF_EN
    check("perf.cycle", cycle_cnt, 32'd12);
    check("perf.instr", instr_cnt, 32'd3);
`else
    check("perf.cycle_off", cycle_cnt, 32'd0);
    check("perf.instr_off", instr_cnt, 32'd0);
`endif

    // subu
    startInstr(6'b000000, 6'b100011);
    tick(); tick();
    check("subu.exe.aluop", ALUOp, 2'b01);
    tick();
    check("subu.wb.regdst", RegDst, 2'b01);
    tick();
    endInstr("subu", 4);

    // ori and lui
    startInstr(6'b001101, 6'b000000);
    tick(); tick();
    check("ori.exe.state", state_o, S_EXEC_I);
    check("ori.exe.extop", ExtOp, 2'b00);
    check("ori.exe.aluop", ALUOp, 2'b10);
    check("ori.exe.alusrcb", ALUSrcB, 2'b10);
    tick();
    check("ori.wb.regdst", RegDst, 2'b00);
    check("ori.wb.regwrite", RegWrite, 1'b1);
    tick();
    endInstr("ori", 4);
    startInstr(6'b001111, 6'b000000);
    tick(); tick();
    check("lui.exe.extop", ExtOp, 2'b10);
    check("lui.exe.aluop", ALUOp, 2'b11);
    tick(); tick();
    endInstr("lui", 4);

    // lw with two wait states in MEM_RD
    startInstr(6'b100011, 6'b000000);
    tick(); tick();
    check("lw.adr.state", state_o, S_MEM_ADR);
    check("lw.adr.alusrcb", ALUSrcB, 2'b10);
    check("lw.adr.extop", ExtOp, 2'b01);
    tick();
    for (int s = 0; s < 3; s++) begin
      mem_ready = (s == 2);
      #1;
      check("lw.rd.state", state_o, S_MEM_RD);
      check("lw.rd.iord", IorD, 1'b1);
      check("lw.rd.regwrite", RegWrite, 1'b0);
      tick();
    end
    check("lw.wb.state", state_o, S_MEM_WB);
    check("lw.wb.regwrite", RegWrite, 1'b1);
    check("lw.wb.memtoreg", MemtoReg, 2'b01);
    check("lw.wb.done", instr_done, 1'b1);
    tick();
    endInstr("lw", 7);

    // beq with zero=1 then zero=0: control is identical either way
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      startInstr(6'b000100, 6'b000000);
      tick(); tick();
      check("beq.state", state_o, S_BRANCH);
      check("beq.pcwcond", PCWriteCond, 1'b1);
      check("beq.pcsrc", PCSource, 2'b01);
      check("beq.pcwrite", PCWrite, 1'b0);
      check("beq.aluop", ALUOp, 2'b01);
      tick();
      endInstr("beq", 3);
    end

    // jal, j, jr
    startInstr(6'b000011, 6'b000000);
    tick(); tick();
    check("jal.state", state_o, S_JAL);
    check("jal.pcwrite", PCWrite, 1'b1);
    check("jal.pcsrc", PCSource, 2'b10);
    check("jal.regdst", RegDst, 2'b10);
    check("jal.memtoreg", MemtoReg, 2'b10);
    check("jal.regwrite", RegWrite, 1'b1);
    tick();
    endInstr("jal", 3);
    startInstr(6'b000010, 6'b000000);
    tick(); tick();
    check("j.state", state_o, S_JUMP);
    check("j.pcsrc", PCSource, 2'b10);
    check("j.regwrite", RegWrite, 1'b0);
    tick();
    endInstr("j", 3);
    startInstr(6'b000000, 6'b001000);
    tick(); tick();
    check("jr.state", state_o, S_JR);
    check("jr.flag", jr, 1'b1);
    check("jr.pcsrc", PCSource, 2'b11);
    check("jr.pcwrite", PCWrite, 1'b1);
    tick();
    endInstr("jr", 3);

    // illegal opcode
    startInstr(6'b111111, 6'b000000);
    tick();
    check("ill.pulse", illegal, 1'b1);
    check("ill.regwrite", RegWrite, 1'b0);
    check("ill.done", instr_done, 1'b0);
    tick();
    endInstr("illegal", 2);
    check("ill.clear", illegal, 1'b0);

    // sw with no wait states
    startInstr(6'b101011, 6'b000000);
    tick(); tick(); tick();
    check("sw.wr.state", state_o, S_MEM_WR);
    check("sw.wr.memwrite", MemWrite, 1'b1);
    check("sw.wr.done", instr_done, 1'b1);
    tick();
    endInstr("sw", 4);

    // sw held off 14 cycles then ready in the limit cycle: completes normally
    startInstr(6'b101011, 6'b000000);
    tick(); tick(); tick();
    mem_ready = 1'b0; errSeen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      #1; errSeen |= mem_err; tick();
    end
    mem_ready = 1'b1; #1;
    check("swlim.state", state_o, S_MEM_WR);
    check("swlim.memwrite", MemWrite, 1'b1);
    check("swlim.noerr", errSeen | mem_err, 1'b0);
    tick();
    endInstr("sw_limit", 18);

    // sw held off 15 cycles: timeout
    startInstr(6'b101011, 6'b000000);
    tick(); tick(); tick();
    mem_ready = 1'b0; wrSeen = 1'b0; errSeen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      #1; wrSeen |= MemWrite; errSeen |= mem_err; tick();
    end
    check("swto.early_err", errSeen, 1'b0);
    check("swto.state", state_o, S_MEM_WR);
    check("swto.mem_err", mem_err, 1'b1);
    check("swto.done", instr_done, 1'b0);
    wrSeen |= MemWrite;
    tick();
    check("swto.back", state_o, S_FETCH);
    check("swto.err_clear", mem_err, 1'b0);
    check("swto.irwrite", IRWrite, 1'b0);
    check("swto.nowrite", wrSeen, 1'b0);
    $display("txn sw_timeout cycles=%0d", cyc - t0);
    mem_ready = 1'b1;
    #1;

    // reset asserted in the middle of MEM_WR
    startInstr(6'b101011, 6'b000000);
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    check("rstwr.state", state_o, S_MEM_WR);
    check("rstwr.iord", IorD, 1'b1);
    rst_n = 1'b0; #1;
    check("rstwr.state0", state_o, S_FETCH);
    check("rstwr.memwrite", MemWrite, 1'b0);
    check("rstwr.iord0", IorD, 1'b0);
    check("rstwr.memread", MemRead, 1'b0);
    mem_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1; #1;
    check("rstwr.fetch", state_o, S_FETCH);
    check("rstwr.memread1", MemRead, 1'b1);
    tick();
    check("rstwr.decode", state_o, S_DECODE);
    check("rstwr.nowrite", MemWrite | RegWrite, 1'b0);
    $display("txn reset_mid_sw");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
